// File: rtl/decode_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_ctrl_pkg
// Purpose  : Shared encodings for the decode-stage hazard controller:
//            forwarding select values, control FSM states and the GRF
//            register index width.
// Revision : 1.0 - initial release
// ============================================================================
package decode_hazard_ctrl_pkg;

    localparam int REGIDX_W = 5;

    // Operand source for the ID stage. Value 3 is reserved and never driven.
    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    // CTRL_CSR_DRAIN holds ID until the issued CSR instruction retires.
    typedef enum logic [0:0] {
        CTRL_IDLE      = 1'b0,
        CTRL_CSR_DRAIN = 1'b1
    } ctrl_state_e;

endpackage : decode_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/decode_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_ctrl_if
// Purpose  : Bundles the pipeline-side signals of the decode hazard
//            controller. Signal names are from the controller's viewpoint
//            (i_* into the controller, o_* out of it).
//   master : pipeline side  - drives ID/EX/MEM/WB status, reads controls
//   slave  : controller     - reads status, drives stall/flush/forward
// Revision : 1.0 - initial release
// ============================================================================
interface decode_hazard_ctrl_if #(
    parameter int REGIDX_W = decode_hazard_ctrl_pkg::REGIDX_W
);
    // ID stage
    logic                i_IdValid_1;
    logic [REGIDX_W-1:0] i_IdRs1_5;
    logic [REGIDX_W-1:0] i_IdRs2_5;
    logic [REGIDX_W-1:0] i_IdRd_5;
    logic                i_IdUseRs1_1;
    logic                i_IdUseRs2_1;
    logic                i_IdWen_1;
    logic                i_IdCsr_1;
    logic                i_IdLong_1;
    // EX / MEM stages
    logic [REGIDX_W-1:0] i_ExRd_5;
    logic                i_ExWen_1;
    logic                i_ExLoad_1;
    logic [REGIDX_W-1:0] i_MemRd_5;
    logic                i_MemWen_1;
    // Multi-cycle unit writeback, redirect, CSR retire
    logic                i_LongDone_1;
    logic [REGIDX_W-1:0] i_LongRd_5;
    logic                i_Redirect_1;
    logic                i_CsrRetire_1;
    // Controls
    logic                o_StallIf_1;
    logic                o_StallId_1;
    logic                o_FlushId_1;
    logic                o_BubbleEx_1;
    logic [1:0]          o_Fwd1Sel_2;
    logic [1:0]          o_Fwd2Sel_2;
    logic                o_LongBusy_1;

    modport master (
        output i_IdValid_1, i_IdRs1_5, i_IdRs2_5, i_IdRd_5,
               i_IdUseRs1_1, i_IdUseRs2_1, i_IdWen_1, i_IdCsr_1, i_IdLong_1,
               i_ExRd_5, i_ExWen_1, i_ExLoad_1, i_MemRd_5, i_MemWen_1,
               i_LongDone_1, i_LongRd_5, i_Redirect_1, i_CsrRetire_1,
        input  o_StallIf_1, o_StallId_1, o_FlushId_1, o_BubbleEx_1,
               o_Fwd1Sel_2, o_Fwd2Sel_2, o_LongBusy_1
    );

    modport slave (
        input  i_IdValid_1, i_IdRs1_5, i_IdRs2_5, i_IdRd_5,
               i_IdUseRs1_1, i_IdUseRs2_1, i_IdWen_1, i_IdCsr_1, i_IdLong_1,
               i_ExRd_5, i_ExWen_1, i_ExLoad_1, i_MemRd_5, i_MemWen_1,
               i_LongDone_1, i_LongRd_5, i_Redirect_1, i_CsrRetire_1,
        output o_StallIf_1, o_StallId_1, o_FlushId_1, o_BubbleEx_1,
               o_Fwd1Sel_2, o_Fwd2Sel_2, o_LongBusy_1
    );

endinterface : decode_hazard_ctrl_if
`default_nettype wire

// File: rtl/decode_hazard_ctrl_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : One pending-writeback bit per GRF register. A bit is set when
//            a multi-cycle op writing that register issues and cleared when
//            the unit writes it back. Two source read ports plus a
//            destination check port.
//   i_Clk, i_Rst         : clock, asynchronous active-high reset
//   i_SetEn / i_SetIdx   : mark register pending (x0 is never marked)
//   i_ClrEn / i_ClrIdx   : writeback completed for register
//   i_Rd1Idx / i_Rd2Idx  : source lookups  -> o_Rd1Busy / o_Rd2Busy
//   i_RdIdx              : destination lookup -> o_RdBusy
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_NUM  = 32,
    parameter int REGIDX_W = 5
) (
    input  wire logic                i_Clk,
    input  wire logic                i_Rst,
    input  wire logic                i_SetEn,
    input  wire logic [REGIDX_W-1:0] i_SetIdx,
    input  wire logic                i_ClrEn,
    input  wire logic [REGIDX_W-1:0] i_ClrIdx,
    input  wire logic [REGIDX_W-1:0] i_Rd1Idx,
    input  wire logic [REGIDX_W-1:0] i_Rd2Idx,
    input  wire logic [REGIDX_W-1:0] i_RdIdx,
    output logic                     o_Rd1Busy,
    output logic                     o_Rd2Busy,
    output logic                     o_RdBusy
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    // Clear is applied before set so that a new issue to the register being
    // written back in the same cycle keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (i_ClrEn) begin
            busy_d[i_ClrIdx] = 1'b0;
        end
        if (i_SetEn && (i_SetIdx != '0)) begin
            busy_d[i_SetIdx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_Rd1Busy = busy_q[i_Rd1Idx];
    assign o_Rd2Busy = busy_q[i_Rd2Idx];
    assign o_RdBusy  = busy_q[i_RdIdx];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/decode_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_hazard_ctrl
// Purpose  : Decode-stage pipeline controller. Decides issue / stall /
//            flush for the instruction in ID, drives the ID operand forward
//            selects, tracks the single outstanding mul/div op and
//            serialises CSR instructions until they retire.
//   i_Clk, i_Rst : clock, asynchronous active-high reset
//   bus (slave)  : ID/EX/MEM status in, stall/flush/bubble/forward out
// Revision : 1.0 - initial release
// ============================================================================
module decode_hazard_ctrl #(
    parameter int REG_NUM  = 32,
    parameter int REGIDX_W = 5,
    parameter int FWD_EN   = 1
) (
    input  wire logic           i_Clk,
    input  wire logic           i_Rst,
    decode_hazard_ctrl_if.slave bus
);
    import decode_hazard_ctrl_pkg::*;

    ctrl_state_e state_q, state_d;
    logic        long_busy_q, long_busy_d;

    logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
    logic w_sb_rs1, w_sb_rs2, w_sb_rd;
    logic w_loaduse, w_sbhaz, w_longbusy, w_csrhaz, w_fwdhaz;
    logic w_stall, w_issue;
    fwd_sel_e w_fwd1, w_fwd2;

    // x0 is hard-wired zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [REGIDX_W-1:0] src,
                                     input logic [REGIDX_W-1:0] dst,
                                     input logic                wen);
        return wen && (src != '0) && (src == dst);
    endfunction

    // A load in EX has no result yet, so it falls through to the MEM check;
    // the load-use stall covers that case.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit,
                                          input logic ex_load,
                                          input logic mem_hit);
        if (ex_hit && !ex_load) return FWD_EX;
        if (mem_hit)            return FWD_MEM;
        return FWD_GRF;
    endfunction

    assign w_ex_hit1  = reg_hit(bus.i_IdRs1_5, bus.i_ExRd_5,  bus.i_ExWen_1);
    assign w_ex_hit2  = reg_hit(bus.i_IdRs2_5, bus.i_ExRd_5,  bus.i_ExWen_1);
    assign w_mem_hit1 = reg_hit(bus.i_IdRs1_5, bus.i_MemRd_5, bus.i_MemWen_1);
    assign w_mem_hit2 = reg_hit(bus.i_IdRs2_5, bus.i_MemRd_5, bus.i_MemWen_1);

    reg_scoreboard #(
        .REG_NUM  (REG_NUM),
        .REGIDX_W (REGIDX_W)
    ) u_scoreboard (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_SetEn  (w_issue && bus.i_IdLong_1 && bus.i_IdWen_1),
        .i_SetIdx (bus.i_IdRd_5),
        .i_ClrEn  (bus.i_LongDone_1),
        .i_ClrIdx (bus.i_LongRd_5),
        .i_Rd1Idx (bus.i_IdRs1_5),
        .i_Rd2Idx (bus.i_IdRs2_5),
        .i_RdIdx  (bus.i_IdRd_5),
        .o_Rd1Busy(w_sb_rs1),
        .o_Rd2Busy(w_sb_rs2),
        .o_RdBusy (w_sb_rd)
    );

    always_comb begin
        w_fwd1   = FWD_GRF;
        w_fwd2   = FWD_GRF;
        w_fwdhaz = 1'b0;
        if (FWD_EN != 0) begin
            w_fwd1 = fwd_pick(w_ex_hit1, bus.i_ExLoad_1, w_mem_hit1);
            w_fwd2 = fwd_pick(w_ex_hit2, bus.i_ExLoad_1, w_mem_hit2);
        end else begin
            w_fwdhaz = bus.i_IdValid_1 &&
                       ((bus.i_IdUseRs1_1 && (w_ex_hit1 || w_mem_hit1)) ||
                        (bus.i_IdUseRs2_1 && (w_ex_hit2 || w_mem_hit2)));
        end
    end

    assign w_loaduse  = bus.i_IdValid_1 && bus.i_ExLoad_1 &&
                        ((bus.i_IdUseRs1_1 && w_ex_hit1) ||
                         (bus.i_IdUseRs2_1 && w_ex_hit2));
    // Destination check catches WAW against a pending long-op writeback.
    assign w_sbhaz    = bus.i_IdValid_1 &&
                        ((bus.i_IdUseRs1_1 && w_sb_rs1) ||
                         (bus.i_IdUseRs2_1 && w_sb_rs2) ||
                         (bus.i_IdWen_1    && w_sb_rd));
    assign w_longbusy = bus.i_IdValid_1 && bus.i_IdLong_1 && long_busy_q;
    assign w_csrhaz   = bus.i_IdValid_1 && (state_q == CTRL_CSR_DRAIN);

    assign w_stall = w_loaduse || w_sbhaz || w_longbusy || w_csrhaz || w_fwdhaz;
    assign w_issue = bus.i_IdValid_1 && !w_stall && !bus.i_Redirect_1;

    // Next-state logic: CSR serialisation FSM and the long-op busy flag.
    always_comb begin
        state_d     = state_q;
        long_busy_d = long_busy_q;
        unique case (state_q)
            CTRL_IDLE: begin
                if (w_issue && bus.i_IdCsr_1) state_d = CTRL_CSR_DRAIN;
            end
            CTRL_CSR_DRAIN: begin
                if (bus.i_CsrRetire_1) state_d = CTRL_IDLE;
            end
            default: state_d = CTRL_IDLE;
        endcase
        if (bus.i_LongDone_1)            long_busy_d = 1'b0;
        if (w_issue && bus.i_IdLong_1)   long_busy_d = 1'b1;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= CTRL_IDLE;
            long_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_busy_q <= long_busy_d;
        end
    end

    // Outputs are forced low for the whole time reset is held, independent
    // of whatever the pipeline presents on the inputs.
    assign bus.o_StallIf_1  = !i_Rst && w_stall && !bus.i_Redirect_1;
    assign bus.o_StallId_1  = !i_Rst && w_stall && !bus.i_Redirect_1;
    assign bus.o_FlushId_1  = !i_Rst && bus.i_Redirect_1;
    assign bus.o_BubbleEx_1 = !i_Rst && (w_stall || bus.i_Redirect_1);
    assign bus.o_Fwd1Sel_2  = i_Rst ? 2'd0 : w_fwd1;
    assign bus.o_Fwd2Sel_2  = i_Rst ? 2'd0 : w_fwd2;
    assign bus.o_LongBusy_1 = !i_Rst && long_busy_q;

endmodule : decode_hazard_ctrl
`default_nettype wire

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Pipeline controller that sequences the decode stage of the 5-stage RV64 core.
- Decides each cycle whether the instruction in ID issues to EX, stalls or is flushed.
- Drives GRF operand forwarding selects for ID.
- Tracks pending writebacks of multi-cycle (mul/div) ops with a register scoreboard, and serializes CSR instructions until they retire.

Parameters:
- REG_NUM, 32, number of architectural GRF registers.
- REGIDX_W, 5, register index width.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = every EX/MEM RAW match stalls and forward selects stay 0.

Ports:
- i_Clk  in  1  core clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_IdValid_1  in  1  valid instruction in ID.
- i_IdRs1_5 / i_IdRs2_5 / i_IdRd_5  in  5 each  ID source and destination indices.
- i_IdUseRs1_1 / i_IdUseRs2_1 / i_IdWen_1  in  1 each  ID reads rs1, reads rs2, writes rd.
- i_IdCsr_1  in  1  ID instruction is a CSR access.
- i_IdLong_1  in  1  ID instruction is a mul/div (multi-cycle unit).
- i_ExRd_5, i_ExWen_1, i_ExLoad_1  in  5,1,1  instruction currently in EX.
- i_MemRd_5, i_MemWen_1  in  5,1  instruction currently in MEM.
- i_LongDone_1, i_LongRd_5  in  1,5  mul/div unit writes GRF this cycle.
- i_Redirect_1  in  1  taken branch/jump/trap redirect from EX.
- i_CsrRetire_1  in  1  CSR instruction retires in WB this cycle.
- o_StallIf_1  out  1  hold PC and the IF/ID register.
- o_StallId_1  out  1  hold ID.
- o_FlushId_1  out  1  invalidate the IF/ID register.
- o_BubbleEx_1  out  1  load a NOP into ID/EX.
- o_Fwd1Sel_2 / o_Fwd2Sel_2  out  2 each  operand source: 0 GRF, 1 EX result, 2 MEM result, 3 reserved (never driven).
- o_LongBusy_1  out  1  a mul/div op is outstanding.

Behaviour:
- Reset:
  - All outputs 0, scoreboard cleared, FSM in IDLE, long-busy flag 0.
  - Reset asserted mid-operation discards all pending state immediately.
- Register x0 never matches anything: no hazard, forward select 0.
- Forwarding (FWD_EN=1):
  - Select = 1 if rs==ExRd and ExWen and !ExLoad.
  - Otherwise select = 2 if rs==MemRd and MemWen.
  - Otherwise select = 0. EX has priority over MEM.
  - Forward selects are combinational and valid even while stalled.
- Hazard terms (only evaluated when i_IdValid_1 is high):
  - loaduse: a used rs matches ExRd with ExWen & ExLoad.
  - sbhaz: a used rs, or rd when IdWen, has its scoreboard bit set (covers RAW and WAW).
  - longbusy: i_IdLong_1 while a long op is outstanding. One long op is outstanding at most.
  - csrhaz: FSM is in CSR_DRAIN.
  - fwdhaz (FWD_EN=0 only): any EX/MEM RAW match.
- stall = loaduse | sbhaz | longbusy | csrhaz | fwdhaz.
  - On stall: o_StallIf_1 = o_StallId_1 = o_BubbleEx_1 = 1.
- Redirect has priority over stall:
  - o_FlushId_1 = o_BubbleEx_1 = 1, stalls = 0.
  - The ID instruction does not issue and no state is updated by it.
- Issue = i_IdValid_1 & !stall & !i_Redirect_1. On issue:
  - If i_IdLong_1 & i_IdWen_1 and rd != 0: set the scoreboard bit for rd and set long-busy on the next edge.
  - If i_IdLong_1 with no rd write: set long-busy only.
  - If i_IdCsr_1: FSM IDLE -> CSR_DRAIN.
- Long completion:
  - i_LongDone_1 clears bit LongRd and clears long-busy on the next edge.
  - A stall caused by that bit deasserts in the cycle after done.
  - If issue and done occur in the same cycle, set and clear are both applied. A new issue to the same rd leaves the bit set.
- FSM:
  - IDLE -> CSR_DRAIN on CSR issue.
  - CSR_DRAIN -> IDLE on i_CsrRetire_1. ID may issue in the following cycle.
  - i_Redirect_1 while in CSR_DRAIN flushes ID and stays in CSR_DRAIN.
  - i_CsrRetire_1 while in IDLE is ignored.
- o_LongBusy_1 is the registered long-busy flag.

Decomposition:
- Shared package contents:
  - FWD_GRF, FWD_EX, FWD_MEM encodings.
  - FSM state encodings CTRL_IDLE, CTRL_CSR_DRAIN.
  - REGIDX_W.
- One natural sub-module: reg_scoreboard (REG_NUM-bit set/clear vector with two read ports plus rd check).
- Forwarding and stall logic stay in the top level.

Test Plan:
- ALU in EX writes x5, ID reads rs1=x5 -> o_Fwd1Sel_2=1, no stall. Same with the writer in MEM -> 2. With both EX and MEM writing x5 -> 1. rs1=x0 -> 0.
- Load in EX to x7, ID uses rs2=x7 -> exactly 1 cycle of StallIf/StallId/BubbleEx. Next cycle the load is in MEM -> o_Fwd2Sel_2=2 and the instruction issues.
- DIV to x10 issues. A dependent add on x10 stalls until LongDone with rd=10, plus 1 cycle. A second MUL stalls while o_LongBusy_1=1. WAW (rd=x10) stalls the same way.
- CSR issues, then 4 cycles later i_CsrRetire_1 -> ID stalled for all intervening cycles; issue resumes the cycle after retire.
- Redirect coincident with a load-use stall -> FlushId=1, BubbleEx=1, StallIf=0. Scoreboard and FSM unchanged.
- Assert i_Rst mid-DIV while in CSR_DRAIN -> all outputs 0 asynchronously, scoreboard clear, FSM IDLE. After release, the first instruction issues without stall.
